// File: rtl/cp_arbiter_pkg.sv
// cp_arbiter_pkg: types and constants shared by the CDB arbiter and stage_cp.
//   NUM_FU     number of functional-unit result ports (ALU x2, MULT, LOAD, BRANCH)
//   CDB_WIDTH  CDB slots per cycle; must match the stage_cp width
//   EX_PACKET  FU result packet; .valid doubles as the arbitration request
package cp_arbiter_pkg;

  localparam int NUM_FU    = 5;
  localparam int CDB_WIDTH = 3;
  localparam int FU_IDX_W  = $clog2(NUM_FU);

  typedef struct packed {
    logic [31:0] NPC;
    logic [31:0] value;
    logic [5:0]  T;
    logic        halt;
    logic        branch_taken;
    logic        valid;
  } EX_PACKET;

endpackage

// File: rtl/cp_arbiter_rr_multi_select.sv
// rr_multi_select: combinational round-robin picker that grants up to
// CDB_WIDTH of NUM_FU requesters, scanning from rr_ptr with wrap-around.
//   req         request vector, one bit per FU
//   rr_ptr      FU index where the scan starts
//   grant       one-hot-per-FU grant vector
//   slot_idx    FU index feeding each CDB slot, compacted lowest-first
//   slot_valid  slot is occupied
//   next_ptr    last granted FU + 1 (mod NUM_FU), or rr_ptr if nothing granted
module rr_multi_select
  import cp_arbiter_pkg::*;
(
  input  logic [NUM_FU-1:0]                   req,
  input  logic [FU_IDX_W-1:0]                 rr_ptr,
  output logic [NUM_FU-1:0]                   grant,
  output logic [CDB_WIDTH-1:0][FU_IDX_W-1:0]  slot_idx,
  output logic [CDB_WIDTH-1:0]                slot_valid,
  output logic [FU_IDX_W-1:0]                 next_ptr
);

  always_comb begin
    int cnt;
    int idx;
    grant      = '0;
    slot_idx   = '0;
    slot_valid = '0;
    next_ptr   = rr_ptr;
    cnt        = 0;
    idx        = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (req[idx] && cnt < CDB_WIDTH) begin
        grant[idx]      = 1'b1;
        slot_idx[cnt]   = FU_IDX_W'(idx);
        slot_valid[cnt] = 1'b1;
        cnt             = cnt + 1;
        next_ptr        = (idx == NUM_FU - 1) ? '0 : FU_IDX_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/cp_arbiter.sv
// cp_arbiter: packs up to CDB_WIDTH FU results per cycle onto the registered
// CDB slots feeding stage_cp, with round-robin fairness across FUs.
//   clock           system clock
//   reset           synchronous, active-high
//   squash          mispredict flush; blocks grants and empties the slots
//   fu_packet_in    FU results; .valid is the request
//   fu_ready        combinational grant; FU may retire its packet at the edge
//   cp_packet_out   registered CDB slots (1-cycle latency)
//   grant_count     (CP_PERF_CNT_EN only) cumulative granted packets
//   conflict_count  (CP_PERF_CNT_EN only) cycles with > CDB_WIDTH requests
// Optional feature macro: CP_PERF_CNT_EN
module cp_arbiter
  import cp_arbiter_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  EX_PACKET [NUM_FU-1:0]        fu_packet_in,
  output logic     [NUM_FU-1:0]        fu_ready,
`ifdef CP_PERF_CNT_EN
  output logic     [31:0]              grant_count,
  output logic     [31:0]              conflict_count,
`endif
  output EX_PACKET [CDB_WIDTH-1:0]     cp_packet_out
);

  logic [FU_IDX_W-1:0]                rr_ptr;
  logic [NUM_FU-1:0]                  req;
  logic [NUM_FU-1:0]                  grant;
  logic [CDB_WIDTH-1:0][FU_IDX_W-1:0] slot_idx;
  logic [CDB_WIDTH-1:0]               slot_valid;
  logic [FU_IDX_W-1:0]                next_ptr;

  // Gating the requests (rather than the grants) keeps fu_ready, slots and
  // the pointer update consistent: a squash/reset cycle simply has no grants.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_FU; i++)
      req[i] = fu_packet_in[i].valid & ~squash & ~reset;
  end

  rr_multi_select u_sel (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .grant      (grant),
    .slot_idx   (slot_idx),
    .slot_valid (slot_valid),
    .next_ptr   (next_ptr)
  );

  assign fu_ready = grant;

  always_ff @(posedge clock) begin
    if (reset) begin
      cp_packet_out <= '0;
      rr_ptr        <= '0;
    end else if (squash) begin
      cp_packet_out <= '0;
    end else begin
      // Empty slots are forced to zero so no stale field reaches stage_cp.
      for (int k = 0; k < CDB_WIDTH; k++)
        cp_packet_out[k] <= slot_valid[k] ? fu_packet_in[slot_idx[k]] : '0;
      if (|grant) rr_ptr <= next_ptr;
    end
  end

`ifdef CP_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count    <= '0;
      conflict_count <= '0;
    end else if (!squash) begin
      grant_count <= grant_count + 32'($countones(grant));
      if ($countones(req) > CDB_WIDTH) conflict_count <= conflict_count + 32'd1;
    end
  end
`endif

endmodule
